// File: rtl/cmul_share_arbiter_pkg.sv
// Shared definitions for the complex-multiplier share arbiter:
// parameter defaults, FSM state encoding and the tag record layout.
package cmul_share_arbiter_pkg;

    localparam int WIDTH_DEF     = 24;
    localparam int MUL_LAT_DEF   = 2;
    localparam int MAX_BURST_DEF = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOCK0 = 2'd1;
    localparam logic [1:0] S_LOCK1 = 2'd2;

    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } tag_t;

endpackage

// File: rtl/cmul_share_arbiter_if.sv
// Requester, multiplier and result signals of the share arbiter.
// master = requesters/multiplier side, slave = arbiter side.
interface cmul_share_arbiter_if
    import cmul_share_arbiter_pkg::*;
#(
    parameter int width = WIDTH_DEF
);
    logic             req_valid_0;
    logic             req_ready_0;
    logic             req_last_0;
    logic [width-1:0] req_p_0;
    logic [width-1:0] req_q_0;
    logic             req_valid_1;
    logic             req_ready_1;
    logic             req_last_1;
    logic [width-1:0] req_p_1;
    logic [width-1:0] req_q_1;
    logic [width-1:0] mul_p;
    logic [width-1:0] mul_q;
    logic [width-1:0] mul_r;
    logic             res_valid_0;
    logic             res_valid_1;
    logic             res_last;
    logic [width-1:0] res_data;

    modport master (
        output req_valid_0, req_last_0, req_p_0, req_q_0,
        output req_valid_1, req_last_1, req_p_1, req_q_1,
        output mul_r,
        input  req_ready_0, req_ready_1, mul_p, mul_q,
        input  res_valid_0, res_valid_1, res_last, res_data
    );

    modport slave (
        input  req_valid_0, req_last_0, req_p_0, req_q_0,
        input  req_valid_1, req_last_1, req_p_1, req_q_1,
        input  mul_r,
        output req_ready_0, req_ready_1, mul_p, mul_q,
        output res_valid_0, res_valid_1, res_last, res_data
    );

endinterface

// File: rtl/cmul_share_arbiter_tag_pipe.sv
// Tag delay line that follows each operand pair through the
// multiplier so its result can be steered back to its owner.
module cmul_tag_pipe
    import cmul_share_arbiter_pkg::*;
#(
    parameter int DEPTH = MUL_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  tag_t din,
    output tag_t dout
);

    tag_t pipe [DEPTH];

    // Shift tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/cmul_share_arbiter.sv
// Round-robin, burst-locking arbiter sharing one pipelined complex
// multiplier between two requesters and routing results back.
module cmul_share_arbiter
    import cmul_share_arbiter_pkg::*;
#(
    parameter int width     = WIDTH_DEF,
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input logic                 clk,
    input logic                 rst,
    cmul_share_arbiter_if.slave bus
);

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    logic [1:0] state;
    logic       rr_ptr;
    logic [7:0] beat_cnt;
    logic       gnt_id;
    logic       accept;
    logic       gnt_last;
    logic [7:0] beat_nxt;
    logic       release_lock;
    tag_t       tag_in;
    tag_t       tag_out;

    // Pick the granted requester and decide whether a beat is taken.
    always_comb begin
        gnt_id = rr_ptr;
        accept = 1'b0;
        case (state)
            S_LOCK0: begin
                gnt_id = 1'b0;
                accept = bus.req_valid_0;
            end
            S_LOCK1: begin
                gnt_id = 1'b1;
                accept = bus.req_valid_1;
            end
            default: begin
                if (bus.req_valid_0 && bus.req_valid_1) begin
                    gnt_id = rr_ptr;
                end else begin
                    gnt_id = bus.req_valid_1;
                end
                accept = bus.req_valid_0 | bus.req_valid_1;
            end
        endcase
        if (rst) begin
            accept = 1'b0;
        end
    end

    assign gnt_last = gnt_id ? bus.req_last_1 : bus.req_last_0;
    assign beat_nxt = ((state == S_IDLE) ? 8'd0 : beat_cnt) + 8'd1;
    assign release_lock = gnt_last || (beat_nxt == MAX_B);

    assign bus.req_ready_0 = !rst && ((state == S_LOCK0) ||
        ((state == S_IDLE) && accept && !gnt_id));
    assign bus.req_ready_1 = !rst && ((state == S_LOCK1) ||
        ((state == S_IDLE) && accept && gnt_id));

    assign bus.mul_p = accept ? (gnt_id ? bus.req_p_1 : bus.req_p_0) : '0;
    assign bus.mul_q = accept ? (gnt_id ? bus.req_q_1 : bus.req_q_0) : '0;

    // Lock/release bookkeeping and round-robin pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= 1'b0;
            beat_cnt <= 8'd0;
        end else if (accept) begin
            if (release_lock) begin
                state    <= S_IDLE;
                rr_ptr   <= ~gnt_id;
                beat_cnt <= 8'd0;
            end else begin
                state    <= gnt_id ? S_LOCK1 : S_LOCK0;
                beat_cnt <= beat_nxt;
            end
        end
    end

    assign tag_in = '{valid: accept, id: gnt_id, last: accept & gnt_last};

    cmul_tag_pipe #(
        .DEPTH(MUL_LAT)
    ) u_tag_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign bus.res_valid_0 = tag_out.valid & ~tag_out.id;
    assign bus.res_valid_1 = tag_out.valid & tag_out.id;
    assign bus.res_last    = tag_out.valid & tag_out.last;
    assign bus.res_data    = bus.mul_r;

endmodule
